// File: rtl/disp_pkg.sv
// Shared types and constants for the display sequencing controller.
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] SLOT_UNITS = 2'd0;
    localparam logic [1:0] SLOT_TENS  = 2'd1;
    localparam logic [1:0] SLOT_HUND  = 2'd2;
    localparam logic [1:0] SLOT_SIGN  = 2'd3;

    localparam logic [3:0] SIGN_CODE = 4'hF;

    localparam int unsigned CONV_STEPS = 9;
    localparam int unsigned MAG_W      = 9;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned PRESC_W    = 20;

    // Committed display contents, written atomically at the end of a conversion.
    typedef struct packed {
        logic       sign;
        logic [3:0] bcd2;
        logic [3:0] bcd1;
        logic [3:0] bcd0;
    } disp_regs_t;

endpackage

// File: rtl/bcd_add3_adj.sv
// Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
module bcd_add3_adj
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0] bcd_adj_c
);

    always_comb begin
        bcd_adj_c = bcd_in;
        for (int i = 0; i < 3; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/disp_seq_ctrl.sv
// Signed value to 4-slot multiplexed display sequencer: serial BCD conversion,
// atomic commit of digits/sign, and a free-running anode scan.
module disp_seq_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [8:0] value,
    output logic       busy,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [3:0] digit,
    output logic       blank,
    output logic       minus
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [MAG_W-1:0]     mag_q, mag_d;
    logic                 sign_cap_q, sign_cap_d;
    disp_regs_t           disp_q, disp_d;
    logic                 busy_q, busy_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           an_q, an_d;

    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+MAG_W-1:0] shifted;

    bcd_add3_adj u_add3 (
        .bcd_in    (acc_q),
        .bcd_adj_c (acc_adj)
    );

    assign shifted = {acc_adj, mag_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_q      <= '0;
            sign_cap_q <= 1'b0;
            disp_q     <= '0;
            busy_q     <= 1'b0;
            presc_q    <= '0;
            sel_q      <= SLOT_UNITS;
            an_q       <= 4'b1110;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_q      <= mag_d;
            sign_cap_q <= sign_cap_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            presc_q    <= presc_d;
            sel_q      <= sel_d;
            an_q       <= an_d;
        end
    end

    // Conversion FSM; display regs only change in COMMIT so nothing torn is shown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_d      = mag_q;
        sign_cap_d = sign_cap_q;
        disp_d     = disp_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d    = S_CONV;
                    sign_cap_d = value[8];
                    mag_d      = value[8] ? MAG_W'(-value) : value;
                    acc_d      = '0;
                    cnt_d      = '0;
                end
            end
            S_CONV: begin
                acc_d = shifted[BCD_W+MAG_W-1:MAG_W];
                mag_d = shifted[MAG_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d.sign = sign_cap_q;
                disp_d.bcd2 = acc_q[11:8];
                disp_d.bcd1 = acc_q[7:4];
                disp_d.bcd0 = acc_q[3:0];
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Refresh prescaler and slot scan, independent of the FSM.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        sel_d   = sel_q;
        if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            sel_d   = sel_q + 2'd1;
        end
        an_d = ~(4'b0001 << sel_d);
    end

    // Per-slot decode towards the segment decoder.
    always_comb begin
        digit = disp_q.bcd0;
        blank = 1'b0;
        minus = 1'b0;
        case (sel_q)
            SLOT_UNITS: begin
                digit = disp_q.bcd0;
            end
            SLOT_TENS: begin
                digit = disp_q.bcd1;
                blank = BLANK_LZ & (disp_q.bcd2 == 4'd0) & (disp_q.bcd1 == 4'd0);
            end
            SLOT_HUND: begin
                digit = disp_q.bcd2;
                blank = BLANK_LZ & (disp_q.bcd2 == 4'd0);
            end
            SLOT_SIGN: begin
                digit = SIGN_CODE;
                minus = disp_q.sign;
                blank = ~disp_q.sign;
            end
            default: begin
                digit = disp_q.bcd0;
            end
        endcase
    end

    assign busy = busy_q;
    assign sel  = sel_q;
    assign an   = an_q;

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Scoreboard bench for disp_seq_ctrl with leading-zero blanking on and off.
module tb_disp_seq_ctrl;

    localparam int unsigned RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [8:0] value = '0;

    logic       busy, blank, minus;
    logic [1:0] sel;
    logic [3:0] an, digit;
    logic       busy0, blank0, minus0;
    logic [1:0] sel0;
    logic [3:0] an0, digit0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int d2;
        int d1;
        int d0;
        bit sgn;
    } exp_t;

    exp_t sb[$];

    disp_seq_ctrl #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy), .sel(sel), .an(an), .digit(digit), .blank(blank), .minus(minus)
    );

    disp_seq_ctrl #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy0), .sel(sel0), .an(an0), .digit(digit0), .blank(blank0), .minus(minus0)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int v);
        exp_t e;
        int m;
        m     = (v < 0) ? -v : v;
        e.d2  = m / 100;
        e.d1  = (m / 10) % 10;
        e.d0  = m % 10;
        e.sgn = (v < 0);
        return e;
    endfunction

    // {digit, blank, minus} the segment decoder should see for slot s.
    function automatic logic [5:0] exp_slot(exp_t e, logic [1:0] s, bit blz);
        case (s)
            2'd0:    return {4'(e.d0), 1'b0, 1'b0};
            2'd1:    return {4'(e.d1), blz && (e.d2 == 0) && (e.d1 == 0), 1'b0};
            2'd2:    return {4'(e.d2), blz && (e.d2 == 0), 1'b0};
            default: return {4'hF, !e.sgn, e.sgn};
        endcase
    endfunction

    task automatic drive_load(int v, bit do_push);
        @(negedge clk);
        value = 9'(v);
        load  = 1'b1;
        if (do_push) sb.push_back(model(v));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_busy(string tag);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 10 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_len: got %0d (busy0=%b) expected 10 (busy0=0)", tag, n, busy0);
        end
    endtask

    task automatic check_display(string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
            return;
        end
        checks--;
        e = sb.pop_front();
        for (int s = 0; s < 4; s++) begin
            int n = 0;
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << s);
            while (sel !== 2'(s) && n < 20) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if (n >= 20) begin
                failures++;
                $display("FAIL %s slot%0d_wait: got sel=%0d expected sel=%0d", tag, s, sel, s);
            end else if ({an, digit, blank, minus} !== {exp_an, exp_slot(e, 2'(s), 1'b1)}) begin
                failures++;
                $display("FAIL %s slot%0d: got an=%b digit=%h blank=%b minus=%b expected an=%b dbm=%b",
                         tag, s, an, digit, blank, minus, exp_an, exp_slot(e, 2'(s), 1'b1));
            end
            checks++;
            if ({sel0, an0, digit0, blank0, minus0} !== {2'(s), exp_an, exp_slot(e, 2'(s), 1'b0)}) begin
                failures++;
                $display("FAIL %s slot%0d_nolz: got sel=%0d an=%b digit=%h blank=%b minus=%b expected an=%b dbm=%b",
                         tag, s, sel0, an0, digit0, blank0, minus0, exp_an, exp_slot(e, 2'(s), 1'b0));
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, sel, an, digit, blank, minus} !== {1'b0, 2'd0, 4'b1110, 4'd0, 1'b0, 1'b0} ||
            {busy0, sel0, an0, digit0, blank0, minus0} !== {1'b0, 2'd0, 4'b1110, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got busy=%b sel=%0d an=%b digit=%h blank=%b minus=%b expected 0 0 1110 0 0 0",
                     busy, sel, an, digit, blank, minus);
        end
        rst_n = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            logic [1:0] es;
            @(negedge clk);
            es = 2'((j / 4) % 4);
            checks++;
            if (sel !== es || an !== ~(4'b0001 << es)) begin
                failures++;
                $display("FAIL scan_seq[%0d]: got sel=%0d an=%b expected sel=%0d an=%b",
                         j, sel, an, es, ~(4'b0001 << es));
            end
        end
    endtask

    task automatic test_value(int v, string tag);
        drive_load(v, 1'b1);
        wait_busy(tag);
        check_display(tag);
    endtask

    task automatic test_ignored();
        int n = 0;
        int i = 0;
        @(negedge clk);
        value = 9'(42);
        load  = 1'b1;
        sb.push_back(model(42));
        @(negedge clk);
        load = 1'b0;
        while (busy && n < 40) begin
            if (i == 2 || i == 9) begin
                load  = 1'b1;
                value = 9'(99);
            end else begin
                load = 1'b0;
            end
            n++;
            i++;
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL ignored_busy_len: got %0d expected 10", n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_no_queue: got busy=%b expected 0", busy);
        end
        check_display("ignored_42");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        exp_t e1;
        @(negedge clk);
        value = 9'(7);
        load  = 1'b1;
        sb.push_back(model(7));
        @(negedge clk);
        value = 9'(-9);
        sb.push_back(model(-9));
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL b2b_first_len: got %0d expected 10", n);
        end
        e1 = sb.pop_front();
        checks++;
        if ({digit, blank, minus} !== exp_slot(e1, sel, 1'b1)) begin
            failures++;
            $display("FAIL b2b_first_value: got slot%0d dbm=%b expected %b",
                     sel, {digit, blank, minus}, exp_slot(e1, sel, 1'b1));
        end
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b expected 1", busy);
        end
        wait_busy("b2b_second");
        check_display("b2b_minus9");
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        test_value(77, "pre_abort_77");
        drive_load(200, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sel, an, digit, blank, minus} !== {1'b0, 2'd0, 4'b1110, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_clear: got busy=%b sel=%0d an=%b digit=%h blank=%b minus=%b expected 0 0 1110 0 0 0",
                     busy, sel, an, digit, blank, minus);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_resume: got %0d busy cycles expected 0", seen);
        end
        sb.push_back(model(0));
        check_display("abort_zero");
    endtask

    initial begin
        test_reset();
        test_value(123, "val_123");
        test_value(-256, "val_m256");
        test_value(5, "val_5_blank");
        test_value(255, "val_255");
        test_value(100, "val_100");
        test_value(0, "val_0");
        test_value(-1, "val_m1");
        test_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
